// File: rtl/ps_general_csr_v2.sv
// ---------------------------------------------------------------------------
// ps_general_csr_v2
//
// General-purpose control/status register block for the packet subsystem.
// Provides two scratch registers, a read-only build/status word, the
// synchronized HSSI RX/TX init_done state, sticky change events with an
// interrupt mask, and a 64-bit free-running uptime counter whose high word
// is latched on every low-word read so software sees a coherent pair.
//
// Register map (byte addresses, word aligned; misaligned = unmapped):
//   0x00 scratch0    RW  (byte enables honoured)
//   0x04 status      RO
//   0x08 init_status RO  [i] = rx[i], [16+i] = tx[i]
//   0x0C event       W1C (byte enables honoured, hardware set wins)
//   0x10 irq_mask    RW  (byte enables honoured)
//   0x14 uptime_lo   RO  (read also captures uptime[63:32] into shadow)
//   0x18 uptime_hi   RO  (returns shadow)
//   0x1C scratch1    RW  (byte enables honoured)
//
// Ports:
//   clk, reset_n          clock (rising edge), synchronous active-low reset
//   rx_init_done_i        per-port RX ready, asynchronous to clk
//   tx_init_done_i        per-port TX ready, asynchronous to clk
//   address               byte address of the access
//   read, write           access strobes (may both be high in one cycle)
//   writedata, byteenable write payload and per-byte lane enables
//   readdata              read result, registered
//   readdatavalid         registered copy of read
//   irq_o                 level interrupt, OR of enabled events, registered
//
// Read handshake: there is no back-pressure. A read strobe sampled high at a
// rising edge produces readdatavalid = 1 for exactly one cycle after that
// edge with readdata holding the value the register had before the edge.
// readdata is 0 whenever readdatavalid is 0 or the address is unmapped.
// Writes complete at the edge they are sampled on.
// ---------------------------------------------------------------------------
module ps_general_csr_v2 #(
    parameter int HSSI_PORT   = 2,
    parameter int DMA_CH      = 6,
    parameter int DBG_CNTR_EN = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [HSSI_PORT-1:0] rx_init_done_i,
    input  logic [HSSI_PORT-1:0] tx_init_done_i,
    input  logic [4:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    input  logic [3:0]           byteenable,
    output logic [31:0]          readdata,
    output logic                 readdatavalid,
    output logic                 irq_o
);

    localparam logic [2:0] IDX_SCRATCH0  = 3'd0;
    localparam logic [2:0] IDX_STATUS    = 3'd1;
    localparam logic [2:0] IDX_INIT      = 3'd2;
    localparam logic [2:0] IDX_EVENT     = 3'd3;
    localparam logic [2:0] IDX_IRQ_MASK  = 3'd4;
    localparam logic [2:0] IDX_UPTIME_LO = 3'd5;
    localparam logic [2:0] IDX_UPTIME_HI = 3'd6;
    localparam logic [2:0] IDX_SCRATCH1  = 3'd7;

    // Version 2.0, followed by the build-time configuration fields.
    localparam logic [31:0] STATUS_VAL = {
        11'd0,
        (DBG_CNTR_EN != 0),
        4'(HSSI_PORT),
        4'(DMA_CH / HSSI_PORT),
        4'(HSSI_PORT),
        4'd0,
        4'd2
    };

    // Synchronizers and previous-value history for change detection.
    logic [HSSI_PORT-1:0] rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic [HSSI_PORT-1:0] tx_sync1_q, tx_sync2_q, tx_prev_q;

    logic [31:0] scratch0_q, scratch0_d;
    logic [31:0] scratch1_q, scratch1_d;
    logic [31:0] irq_mask_q, irq_mask_d;
    logic [31:0] event_q,    event_d;
    logic [63:0] uptime_q,   uptime_d;
    logic [31:0] shadow_q,   shadow_d;
    logic [31:0] readdata_q, readdata_d;
    logic        readdatavalid_q, readdatavalid_d;
    logic        irq_q, irq_d;

    logic [31:0] be_mask;
    logic [2:0]  word_idx;
    logic        aligned;
    logic        wr_hit;
    logic        rd_hit;
    logic [31:0] init_status;
    logic [31:0] event_set;
    logic [31:0] event_clr;

    always_comb begin
        be_mask     = {{8{byteenable[3]}}, {8{byteenable[2]}},
                       {8{byteenable[1]}}, {8{byteenable[0]}}};
        word_idx    = address[4:2];
        aligned     = (address[1:0] == 2'b00);
        wr_hit      = write && aligned;
        rd_hit      = read && aligned;

        init_status = {16'(tx_sync2_q), 16'(rx_sync2_q)};
        // Any edge of a synchronized bit, in either direction, is an event.
        event_set   = {16'(tx_sync2_q ^ tx_prev_q), 16'(rx_sync2_q ^ rx_prev_q)};

        scratch0_d  = scratch0_q;
        scratch1_d  = scratch1_q;
        irq_mask_d  = irq_mask_q;
        event_clr   = '0;

        if (wr_hit) begin
            case (word_idx)
                IDX_SCRATCH0: scratch0_d = (scratch0_q & ~be_mask) | (writedata & be_mask);
                IDX_EVENT:    event_clr  = writedata & be_mask;
                IDX_IRQ_MASK: irq_mask_d = (irq_mask_q & ~be_mask) | (writedata & be_mask);
                IDX_SCRATCH1: scratch1_d = (scratch1_q & ~be_mask) | (writedata & be_mask);
                default:      ; // read-only words ignore writes
            endcase
        end

        // Set is OR'ed in after the clear so a simultaneous event survives.
        event_d  = (event_q & ~event_clr) | event_set;
        irq_d    = |(event_q & irq_mask_q);
        uptime_d = uptime_q + 64'd1;

        shadow_d        = shadow_q;
        readdata_d      = '0;
        readdatavalid_d = read;

        // Decode uses current register values, so a same-cycle write is not
        // visible to the read.
        if (rd_hit) begin
            case (word_idx)
                IDX_SCRATCH0:  readdata_d = scratch0_q;
                IDX_STATUS:    readdata_d = STATUS_VAL;
                IDX_INIT:      readdata_d = init_status;
                IDX_EVENT:     readdata_d = event_q;
                IDX_IRQ_MASK:  readdata_d = irq_mask_q;
                IDX_UPTIME_LO: begin
                    readdata_d = uptime_q[31:0];
                    shadow_d   = uptime_q[63:32];
                end
                IDX_UPTIME_HI: readdata_d = shadow_q;
                IDX_SCRATCH1:  readdata_d = scratch1_q;
                default:       readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_sync1_q      <= '0;
            rx_sync2_q      <= '0;
            rx_prev_q       <= '0;
            tx_sync1_q      <= '0;
            tx_sync2_q      <= '0;
            tx_prev_q       <= '0;
            scratch0_q      <= '0;
            scratch1_q      <= '0;
            irq_mask_q      <= '0;
            event_q         <= '0;
            uptime_q        <= '0;
            shadow_q        <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            rx_sync1_q      <= rx_init_done_i;
            rx_sync2_q      <= rx_sync1_q;
            rx_prev_q       <= rx_sync2_q;
            tx_sync1_q      <= tx_init_done_i;
            tx_sync2_q      <= tx_sync1_q;
            tx_prev_q       <= tx_sync2_q;
            scratch0_q      <= scratch0_d;
            scratch1_q      <= scratch1_d;
            irq_mask_q      <= irq_mask_d;
            event_q         <= event_d;
            uptime_q        <= uptime_d;
            shadow_q        <= shadow_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            irq_q           <= irq_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;
    assign irq_o         = irq_q;

endmodule

// File: doc/ps_general_csr_v2.md
PS_GENERAL_CSR_V2 -- requirements
Module: ps_general_csr_v2

Interface
REQ-001 SHALL have parameter HSSI_PORT, default 2, number of HSSI ports (legal range 1..16).
REQ-002 SHALL have parameter DMA_CH, default 6, total DMA channels; DMA_CH/HSSI_PORT SHALL fit in 4 bits.
REQ-003 SHALL have parameter DBG_CNTR_EN, default 0, debug-counter-enabled flag reported in status.
REQ-004 SHALL have port clk, input, 1, clock; all logic is on the rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port rx_init_done_i, input, HSSI_PORT, per-port RX ready (asynchronous to clk).
REQ-007 SHALL have port tx_init_done_i, input, HSSI_PORT, per-port TX ready (asynchronous to clk).
REQ-008 SHALL have ports address (input, 5, byte address), read (input, 1), write (input, 1), writedata (input, 32) and byteenable (input, 4).
REQ-009 SHALL have ports readdata (output, 32), readdatavalid (output, 1) and irq_o (output, 1, level interrupt).

Function
REQ-010 SHALL register readdatavalid = read and readdata = the decoded value, both one cycle after read; readdata SHALL be 0 when read was low or the address is unmapped.
REQ-011 SHALL ignore writes to unmapped or read-only addresses; read and write in the same cycle SHALL both take effect, and the read SHALL return the pre-write value.
REQ-012 SHALL provide address map:
  - 0x00 scratch0 (RW)
  - 0x04 status (RO)
  - 0x08 init_status (RO)
  - 0x0C event (W1C)
  - 0x10 irq_mask (RW)
  - 0x14 uptime_lo (RO)
  - 0x18 uptime_hi (RO)
  - 0x1C scratch1 (RW)
REQ-013 SHALL apply byteenable per byte lane to all RW and W1C registers.
REQ-014 SHALL return in status:
  - [3:0] = 2 (major version)
  - [7:4] = 0 (minor version)
  - [11:8] = HSSI_PORT
  - [15:12] = DMA_CH/HSSI_PORT
  - [19:16] = HSSI_PORT
  - [20] = DBG_CNTR_EN
  - [31:21] = 0
REQ-015 SHALL pass each rx/tx init_done bit through a 2-flop synchronizer; init_status[i] = synced rx[i], init_status[16+i] = synced tx[i]; unused bits read 0.
REQ-016 SHALL keep a previous-value register per synced bit and set the event bit (event[i] rx, event[16+i] tx) on any change, rising or falling.
REQ-017 SHALL make event bits sticky until cleared by writing 1 with the byte enabled; writing 0 SHALL have no effect.
REQ-018 SHALL give a hardware set priority over a W1C clear in the same cycle, so the bit remains 1.
REQ-019 SHALL register irq_o = OR over (event & irq_mask), one cycle after event/mask update; it SHALL deassert one cycle after the last enabled event clears or its mask bit clears.
REQ-020 SHALL keep a 64-bit free-running uptime counter, +1 per clk, wrapping from all-ones to 0.
REQ-021 SHALL, on a read of uptime_lo, return counter[31:0] of the read cycle and capture counter[63:32] of the same cycle into a shadow register; uptime_hi reads SHALL return the shadow, giving a coherent 64-bit pair.

Reset
REQ-022 SHALL, while reset_n = 0 at a clk edge, clear all of: readdata, readdatavalid, irq_o, scratch0, scratch1, irq_mask, event, synchronizer flops, previous-value flops, uptime counter, shadow.
REQ-023 SHALL abort any read issued during reset, with readdatavalid 0 in the following cycle.
REQ-024 SHALL, after reset, treat a constant-high init_done input as a 0->1 change, setting its event bit 3 cycles after reset release.

Verification
REQ-025 SHALL cover: write 0xA5A5A5A5 to 0x00 with byteenable 0x5, then read 0x00 -> 0x00A500A5, readdatavalid exactly 1 cycle after read.
REQ-026 SHALL cover: HSSI_PORT=2, DMA_CH=6, read 0x04 -> 0x00023202.
REQ-027 SHALL cover: raise rx_init_done_i[1] -> init_status = 0x00000002 and event = 0x00000002 within 3 cycles; with irq_mask = 0x2, irq_o = 1 one cycle later; write 0x2 to 0x0C -> irq_o = 0 within 2 cycles.
REQ-028 SHALL cover: W1C to event[16] in the same cycle tx_init_done_i[0] falls (synced edge) -> event[16] stays 1.
REQ-029 SHALL cover: force uptime to 0x00000000_FFFFFFFF, read 0x14 then 0x18 -> 0xFFFFFFFF then 0x00000000, despite the carry into the high word.
REQ-030 SHALL cover: assert reset_n = 0 mid-operation with irq_o = 1 and event nonzero -> all outputs and registers 0 on the next edge, and the scratch registers read 0 after release.
